pk_axil_cmd_master: RTL and testbench

- AXI4-lite master that drives the Pass_keeper_v1_0 register slave from a 128-bit command stream.
- Accepts one command (key, plaintext, ciphertext) via a valid/ready handshake.
- Issues the register write sequence, including the start pulse, then reads back a 128-bit result block.
- Returns the result and an error flag on a response handshake. Sits directly upstream of the Pass_keeper slave port.

---
 rtl/pk_axil_cmd_master.sv | 231 +++++++++++++++++++++++
 tb/tb_pk_axil_cmd_master.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pk_axil_cmd_master.sv
// pk_axil_cmd_master
// AXI4-lite master that loads one command (key, plaintext, ciphertext) into the
// Pass_keeper register slave. It then pulses the start bit and reads back the
// four-word result block. One transaction is outstanding at a time. Every AXI
// valid/ready output is a register, so no valid depends combinationally on a
// ready.
module pk_axil_cmd_master #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [31:0] RESULT_BASE = 32'h34,
    parameter logic [31:0] START_ADDR  = 32'h00,
    parameter logic [31:0] KEY_BASE    = 32'h04,
    parameter logic [31:0] CTEXT_BASE  = 32'h14,
    parameter logic [31:0] PTEXT_BASE  = 32'h24
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [127:0]          cmd_key,
    input  logic [127:0]          cmd_ptext,
    input  logic [127:0]          cmd_ctext,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [127:0]          rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [2:0]            m00_axi_awprot,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    output logic [31:0]           m00_axi_wdata,
    output logic [3:0]            m00_axi_wstrb,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]            m00_axi_arprot,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [31:0]           m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    localparam logic [3:0] LAST_WRITE = 4'd14;

    state_t        state;
    logic [127:0]  key_q;
    logic [127:0]  ptext_q;
    logic [127:0]  ctext_q;
    logic [3:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic          aw_done;
    logic          w_done;
    logic          err;
    logic          aw_fire;
    logic          w_fire;

    // Word 0 of a 128-bit block is its most significant 32 bits.
    function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] w);
        block_word = blk[{~w, 5'd0} +: 32];
    endfunction

    // Write index -> slave register address. Indices 1..12 walk three 4-word
    // groups, so (idx - 1) mod 4 is the word offset within each group.
    function automatic logic [31:0] beat_addr(input logic [3:0] idx);
        logic [31:0] off;
        off = {28'd0, idx[1:0] - 2'd1, 2'b00};
        if (idx >= 4'd1 && idx <= 4'd4)
            beat_addr = KEY_BASE + off;
        else if (idx >= 4'd5 && idx <= 4'd8)
            beat_addr = PTEXT_BASE + off;
        else if (idx >= 4'd9 && idx <= 4'd12)
            beat_addr = CTEXT_BASE + off;
        else
            beat_addr = START_ADDR;
    endfunction

    // Write index -> data. Index 13 raises start; indices 0 and 14 clear it.
    function automatic logic [31:0] beat_data(input logic [3:0] idx, input logic [127:0] key,
                                              input logic [127:0] pt, input logic [127:0] ct);
        logic [1:0] w;
        w = idx[1:0] - 2'd1;
        if (idx >= 4'd1 && idx <= 4'd4)
            beat_data = block_word(key, w);
        else if (idx >= 4'd5 && idx <= 4'd8)
            beat_data = block_word(pt, w);
        else if (idx >= 4'd9 && idx <= 4'd12)
            beat_data = block_word(ct, w);
        else if (idx == 4'd13)
            beat_data = 32'd1;
        else
            beat_data = 32'd0;
    endfunction

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wstrb  = m00_axi_wvalid ? 4'hF : 4'h0;
    assign aw_fire        = m00_axi_awvalid && m00_axi_awready;
    assign w_fire         = m00_axi_wvalid && m00_axi_wready;

    // Command sequencer: write the 15-beat register sequence, read the four
    // result words, then hold the response until the consumer takes it.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= IDLE;
            key_q           <= '0;
            ptext_q         <= '0;
            ctext_q         <= '0;
            wr_idx          <= '0;
            rd_idx          <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            err             <= 1'b0;
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        key_q           <= cmd_key;
                        ptext_q         <= cmd_ptext;
                        ctext_q         <= cmd_ctext;
                        err             <= 1'b0;
                        cmd_ready       <= 1'b0;
                        wr_idx          <= 4'd0;
                        rd_idx          <= 2'd0;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        m00_axi_awaddr  <= ADDR_WIDTH'(beat_addr(4'd0));
                        m00_axi_wdata   <= beat_data(4'd0, cmd_key, cmd_ptext, cmd_ctext);
                        m00_axi_awvalid <= 1'b1;
                        m00_axi_wvalid  <= 1'b1;
                        state           <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    // AW and W complete independently; move on once both have.
                    if (aw_fire) begin
                        m00_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_fire) begin
                        m00_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        m00_axi_bready <= 1'b1;
                        state          <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m00_axi_bvalid && m00_axi_bready) begin
                        err            <= err | (m00_axi_bresp != 2'b00);
                        m00_axi_bready <= 1'b0;
                        if (wr_idx == LAST_WRITE) begin
                            rd_idx          <= 2'd0;
                            m00_axi_araddr  <= ADDR_WIDTH'(RESULT_BASE);
                            m00_axi_arvalid <= 1'b1;
                            state           <= RD_ADDR;
                        end else begin
                            wr_idx          <= wr_idx + 4'd1;
                            m00_axi_awaddr  <= ADDR_WIDTH'(beat_addr(wr_idx + 4'd1));
                            m00_axi_wdata   <= beat_data(wr_idx + 4'd1, key_q, ptext_q, ctext_q);
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= WR_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m00_axi_arvalid && m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m00_axi_rvalid && m00_axi_rready) begin
                        rsp_data[{~rd_idx, 5'd0} +: 32] <= m00_axi_rdata;
                        err            <= err | (m00_axi_rresp != 2'b00);
                        m00_axi_rready <= 1'b0;
                        if (rd_idx == 2'd3) begin
                            rsp_err   <= err | (m00_axi_rresp != 2'b00);
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rd_idx          <= rd_idx + 2'd1;
                            m00_axi_araddr  <= ADDR_WIDTH'(RESULT_BASE + {28'd0, rd_idx + 2'd1, 2'b00});
                            m00_axi_arvalid <= 1'b1;
                            state           <= RD_ADDR;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pk_axil_cmd_master.sv
// tb_pk_axil_cmd_master
// Directed bench for the Pass_keeper AXI4-lite command master. A small slave
// model with programmable AW/W ready delays logs every accepted beat. Each
// test task compares the logs and responses against hand-computed values.
`timescale 1ns/1ps
module tb_pk_axil_cmd_master;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [127:0]  cmd_key;
    logic [127:0]  cmd_ptext;
    logic [127:0]  cmd_ctext;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [127:0]  rsp_data;
    logic          rsp_err;
    logic [31:0]   m00_axi_awaddr;
    logic [2:0]    m00_axi_awprot;
    logic          m00_axi_awvalid;
    logic          m00_axi_awready;
    logic [31:0]   m00_axi_wdata;
    logic [3:0]    m00_axi_wstrb;
    logic          m00_axi_wvalid;
    logic          m00_axi_wready;
    logic [1:0]    m00_axi_bresp;
    logic          m00_axi_bvalid;
    logic          m00_axi_bready;
    logic [31:0]   m00_axi_araddr;
    logic [2:0]    m00_axi_arprot;
    logic          m00_axi_arvalid;
    logic          m00_axi_arready;
    logic [31:0]   m00_axi_rdata;
    logic [1:0]    m00_axi_rresp;
    logic          m00_axi_rvalid;
    logic          m00_axi_rready;

    always #5 clk = ~clk;

    pk_axil_cmd_master dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_key         (cmd_key),
        .cmd_ptext       (cmd_ptext),
        .cmd_ctext       (cmd_ctext),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .m00_axi_awaddr  (m00_axi_awaddr),
        .m00_axi_awprot  (m00_axi_awprot),
        .m00_axi_awvalid (m00_axi_awvalid),
        .m00_axi_awready (m00_axi_awready),
        .m00_axi_wdata   (m00_axi_wdata),
        .m00_axi_wstrb   (m00_axi_wstrb),
        .m00_axi_wvalid  (m00_axi_wvalid),
        .m00_axi_wready  (m00_axi_wready),
        .m00_axi_bresp   (m00_axi_bresp),
        .m00_axi_bvalid  (m00_axi_bvalid),
        .m00_axi_bready  (m00_axi_bready),
        .m00_axi_araddr  (m00_axi_araddr),
        .m00_axi_arprot  (m00_axi_arprot),
        .m00_axi_arvalid (m00_axi_arvalid),
        .m00_axi_arready (m00_axi_arready),
        .m00_axi_rdata   (m00_axi_rdata),
        .m00_axi_rresp   (m00_axi_rresp),
        .m00_axi_rvalid  (m00_axi_rvalid),
        .m00_axi_rready  (m00_axi_rready)
    );

    // Test vectors and the register sequence they must produce.
    localparam logic [127:0] KEY   = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] PTEXT = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CTEXT = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [31:0] EXP_ADDR [15] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h24, 32'h28, 32'h2C,
        32'h30, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h00, 32'h00};
    localparam logic [31:0] EXP_DATA [15] = '{
        32'h00000000, 32'h54686174, 32'h73206D79, 32'h204B756E, 32'h67204675,
        32'h54776F20, 32'h4F6E6520, 32'h4E696E65, 32'h2054776F,
        32'h29C3505F, 32'h571420F6, 32'h402299B3, 32'h1A02D73A,
        32'h00000001, 32'h00000000};
    localparam logic [31:0] EXP_RADDR [4] = '{32'h34, 32'h38, 32'h3C, 32'h40};

    int checks_total;
    int checks_passed;

    // Slave configuration, written only by the test tasks.
    int          aw_delay;
    int          w_delay;
    int          err_idx;
    int          clr_req;
    logic [31:0] rd_words [4];

    // Slave model state, written only by the model process.
    int          clr_seen;
    int          aw_n, w_n, ar_n;
    int          aw_done_n, w_done_n, b_issued, rd_issued, viol;
    int          aw_wait, w_wait;
    bit          aw_pend, w_pend, b_pend, ar_pend, r_pend;
    bit          awv_prev, wv_prev;
    logic [31:0] awaddr_prev, wdata_prev;
    logic [31:0] aw_log [32];
    logic [31:0] w_log [32];
    logic [3:0]  ws_log [32];
    logic [31:0] ar_log [8];

    // AXI4-lite slave model, evaluated on the falling edge: it retires the
    // handshakes of the last rising edge, then sets up the next one.
    always @(negedge clk) begin
        if (!rst_n || clr_req != clr_seen) begin
            clr_seen = clr_req;
            m00_axi_awready = 1'b0; m00_axi_wready = 1'b0; m00_axi_arready = 1'b0;
            m00_axi_bvalid = 1'b0;  m00_axi_bresp = 2'b00;
            m00_axi_rvalid = 1'b0;  m00_axi_rdata = 32'h0; m00_axi_rresp = 2'b00;
            aw_n = 0; w_n = 0; ar_n = 0; aw_done_n = 0; w_done_n = 0;
            b_issued = 0; rd_issued = 0; viol = 0; aw_wait = 0; w_wait = 0;
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            awv_prev = 0; wv_prev = 0; awaddr_prev = 32'h0; wdata_prev = 32'h0;
        end else begin
            if (aw_pend && m00_axi_awvalid) viol++;
            if (w_pend && m00_axi_wvalid) viol++;
            if (awv_prev && !aw_pend && !m00_axi_awvalid) viol++;
            if (wv_prev && !w_pend && !m00_axi_wvalid) viol++;
            if (awv_prev && !aw_pend && m00_axi_awvalid && m00_axi_awaddr !== awaddr_prev) viol++;
            if (wv_prev && !w_pend && m00_axi_wvalid && m00_axi_wdata !== wdata_prev) viol++;
            if (!m00_axi_wvalid && m00_axi_wstrb !== 4'h0) viol++;
            if (aw_pend) aw_done_n++;
            if (w_pend) w_done_n++;
            if (b_pend) m00_axi_bvalid = 1'b0;
            if (r_pend) m00_axi_rvalid = 1'b0;
            if (ar_pend) begin
                m00_axi_rvalid = 1'b1;
                m00_axi_rdata  = rd_words[rd_issued % 4];
                m00_axi_rresp  = 2'b00;
                rd_issued++;
            end
            if (!m00_axi_bvalid && b_issued < aw_done_n && b_issued < w_done_n) begin
                m00_axi_bvalid = 1'b1;
                m00_axi_bresp  = (b_issued == err_idx) ? 2'b10 : 2'b00;
                b_issued++;
            end
            m00_axi_awready = 1'b0;
            if (m00_axi_awvalid) begin
                if (aw_wait >= aw_delay) begin m00_axi_awready = 1'b1; aw_wait = 0; end
                else aw_wait++;
            end
            m00_axi_wready = 1'b0;
            if (m00_axi_wvalid) begin
                if (w_wait >= w_delay) begin m00_axi_wready = 1'b1; w_wait = 0; end
                else w_wait++;
            end
            m00_axi_arready = m00_axi_arvalid;
            aw_pend = m00_axi_awvalid && m00_axi_awready;
            w_pend  = m00_axi_wvalid && m00_axi_wready;
            b_pend  = m00_axi_bvalid && m00_axi_bready;
            ar_pend = m00_axi_arvalid && m00_axi_arready;
            r_pend  = m00_axi_rvalid && m00_axi_rready;
            if (aw_pend) begin
                if (aw_n < 32) aw_log[aw_n] = m00_axi_awaddr;
                aw_n++;
            end
            if (w_pend) begin
                if (w_n < 32) begin w_log[w_n] = m00_axi_wdata; ws_log[w_n] = m00_axi_wstrb; end
                w_n++;
            end
            if (ar_pend) begin
                if (ar_n < 8) ar_log[ar_n] = m00_axi_araddr;
                ar_n++;
            end
            awv_prev = m00_axi_awvalid; awaddr_prev = m00_axi_awaddr;
            wv_prev  = m00_axi_wvalid;  wdata_prev  = m00_axi_wdata;
        end
    end

    // Runs one full command against the slave model and returns the response.
    task automatic run_cmd(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c,
                           output logic [127:0] data, output logic err, output bit ok);
        int n;
        ok = 0; data = '0; err = 1'b0;
        clr_req++;
        @(posedge clk); #1;
        cmd_key = k; cmd_ptext = p; cmd_ctext = c; cmd_valid = 1'b1;
        n = 0;
        while (n < 20) begin @(negedge clk); if (cmd_ready) break; n++; end
        if (n >= 20) begin cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (n < 500) begin @(negedge clk); if (rsp_valid) break; n++; end
        if (n >= 500) return;
        data = rsp_data; err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ok = 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if ({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready,
             rsp_valid, rsp_err, m00_axi_wstrb} !== 11'h0)
            $display("FAIL reset_outputs: got awv=%b wv=%b br=%b arv=%b rr=%b rv=%b re=%b ws=%h, want all 0",
                     m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid,
                     m00_axi_rready, rsp_valid, rsp_err, m00_axi_wstrb);
        else checks_passed++;
        checks_total++;
        if (rsp_data !== 128'h0 || m00_axi_awaddr !== 32'h0 || m00_axi_araddr !== 32'h0)
            $display("FAIL reset_data: got rsp_data=%h awaddr=%h araddr=%h, want 0",
                     rsp_data, m00_axi_awaddr, m00_axi_araddr);
        else checks_passed++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
        else checks_passed++;
    endtask

    task automatic test_write_sequence;
        logic [127:0] d;
        logic         e;
        bit           ok;
        aw_delay = 0; w_delay = 0; err_idx = -1;
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(KEY, PTEXT, CTEXT, d, e, ok);
        checks_total++;
        if (ok !== 1'b1) $display("FAIL seq_done: got ok=%b, want 1 (timeout)", ok);
        else checks_passed++;
        checks_total++;
        if (aw_n !== 15 || w_n !== 15 || ar_n !== 4)
            $display("FAIL seq_counts: got aw=%0d w=%0d ar=%0d, want 15 15 4", aw_n, w_n, ar_n);
        else checks_passed++;
        for (int i = 0; i < 15; i++) begin
            checks_total++;
            if (aw_log[i] !== EXP_ADDR[i] || w_log[i] !== EXP_DATA[i] || ws_log[i] !== 4'hF)
                $display("FAIL seq_beat%0d: got addr=%h data=%h strb=%h, want %h %h F",
                         i, aw_log[i], w_log[i], ws_log[i], EXP_ADDR[i], EXP_DATA[i]);
            else checks_passed++;
        end
        for (int i = 0; i < 4; i++) begin
            checks_total++;
            if (ar_log[i] !== EXP_RADDR[i])
                $display("FAIL seq_raddr%0d: got %h, want %h", i, ar_log[i], EXP_RADDR[i]);
            else checks_passed++;
        end
        checks_total++;
        if (d !== 128'h11111111222222223333333344444444 || e !== 1'b0)
            $display("FAIL seq_result: got data=%h err=%b, want 11111111222222223333333344444444 0", d, e);
        else checks_passed++;
        checks_total++;
        if (viol !== 0) $display("FAIL seq_protocol: got %0d violations, want 0", viol);
        else checks_passed++;
    endtask

    task automatic test_ready_skew;
        int           ad [3];
        int           wd [3];
        logic [127:0] d;
        logic         e;
        bit           ok;
        ad = '{0, 3, 2};
        wd = '{3, 0, 2};
        err_idx = -1;
        rd_words = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0};
        for (int t = 0; t < 3; t++) begin
            aw_delay = ad[t]; w_delay = wd[t];
            run_cmd(KEY, PTEXT, CTEXT, d, e, ok);
            checks_total++;
            if (ok !== 1'b1 || viol !== 0 || aw_n !== 15 || w_n !== 15)
                $display("FAIL skew%0d_protocol: got ok=%b viol=%0d aw=%0d w=%0d, want 1 0 15 15",
                         t, ok, viol, aw_n, w_n);
            else checks_passed++;
            for (int i = 0; i < 15; i++) begin
                checks_total++;
                if (aw_log[i] !== EXP_ADDR[i] || w_log[i] !== EXP_DATA[i])
                    $display("FAIL skew%0d_beat%0d: got addr=%h data=%h, want %h %h",
                             t, i, aw_log[i], w_log[i], EXP_ADDR[i], EXP_DATA[i]);
                else checks_passed++;
            end
            checks_total++;
            if (d !== 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0 || e !== 1'b0)
                $display("FAIL skew%0d_result: got data=%h err=%b, want A5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0 0",
                         t, d, e);
            else checks_passed++;
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_bresp_err;
        logic [127:0] d;
        logic         e;
        bit           ok;
        aw_delay = 0; w_delay = 0; err_idx = 7;
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_cmd(KEY, PTEXT, CTEXT, d, e, ok);
        checks_total++;
        if (ok !== 1'b1 || e !== 1'b1 || aw_n !== 15 || ar_n !== 4)
            $display("FAIL berr_flag: got ok=%b err=%b aw=%0d ar=%0d, want 1 1 15 4", ok, e, aw_n, ar_n);
        else checks_passed++;
        checks_total++;
        if (d !== 128'h11111111222222223333333344444444)
            $display("FAIL berr_data: got %h, want 11111111222222223333333344444444", d);
        else checks_passed++;
        err_idx = -1;
        run_cmd(KEY, PTEXT, CTEXT, d, e, ok);
        checks_total++;
        if (ok !== 1'b1 || e !== 1'b0)
            $display("FAIL berr_cleared: got ok=%b err=%b, want 1 0", ok, e);
        else checks_passed++;
    endtask

    task automatic test_rsp_hold;
        int n;
        aw_delay = 0; w_delay = 0; err_idx = -1;
        rd_words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        clr_req++;
        @(posedge clk); #1;
        cmd_key = 128'h000102030405060708090A0B0C0D0E0F; cmd_ptext = PTEXT; cmd_ctext = CTEXT;
        cmd_valid = 1'b1;
        n = 0;
        while (n < 20) begin @(negedge clk); if (cmd_ready) break; n++; end
        @(posedge clk); #1;
        // Keep a different command offered while busy; it must be ignored.
        cmd_key = {4{32'hFFFFFFFF}};
        n = 0;
        while (n < 500) begin @(negedge clk); if (rsp_valid) break; n++; end
        cmd_valid = 1'b0;
        checks_total++;
        if (rsp_valid !== 1'b1 || aw_n !== 15 || w_log[1] !== 32'h00010203)
            $display("FAIL hold_start: got rsp_valid=%b aw=%0d key0=%h, want 1 15 00010203",
                     rsp_valid, aw_n, w_log[1]);
        else checks_passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks_total++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                rsp_data !== 128'hDEADBEEF0123456789ABCDEFCAFEF00D)
                $display("FAIL hold_cycle%0d: got rv=%b cr=%b data=%h, want 1 0 DEADBEEF0123456789ABCDEFCAFEF00D",
                         i, rsp_valid, cmd_ready, rsp_data);
            else checks_passed++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks_total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL hold_release: got rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready);
        else checks_passed++;
        checks_total++;
        if (aw_n !== 15) $display("FAIL hold_no_second_cmd: got aw=%0d, want 15", aw_n);
        else checks_passed++;
    endtask

    task automatic test_reset_mid;
        int           n;
        bit           seen;
        logic [127:0] d;
        logic         e;
        bit           ok;
        aw_delay = 0; w_delay = 0; err_idx = -1;
        rd_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        clr_req++;
        @(posedge clk); #1;
        cmd_key = KEY; cmd_ptext = PTEXT; cmd_ctext = CTEXT; cmd_valid = 1'b1;
        seen = 0; n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (cmd_valid && !cmd_ready) cmd_valid = 1'b0;
            if (m00_axi_awvalid && m00_axi_awaddr == 32'h14) begin seen = 1; break; end
            n++;
        end
        cmd_valid = 1'b0;
        checks_total++;
        if (!seen) $display("FAIL midrst_reach_write9: got timeout, want awvalid at 0x14");
        else checks_passed++;
        #1 rst_n = 1'b0;
        #1;
        checks_total++;
        if ({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid,
             m00_axi_rready, rsp_valid} !== 6'b0)
            $display("FAIL midrst_valids: got awv=%b wv=%b br=%b arv=%b rr=%b rv=%b, want all 0",
                     m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid,
                     m00_axi_rready, rsp_valid);
        else checks_passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || m00_axi_awvalid !== 1'b0)
            $display("FAIL midrst_idle: got cmd_ready=%b rsp_valid=%b awvalid=%b, want 1 0 0",
                     cmd_ready, rsp_valid, m00_axi_awvalid);
        else checks_passed++;
        run_cmd(KEY, PTEXT, CTEXT, d, e, ok);
        checks_total++;
        if (ok !== 1'b1 || e !== 1'b0 || aw_n !== 15 || d !== 128'h11111111222222223333333344444444)
            $display("FAIL midrst_recover: got ok=%b err=%b aw=%0d data=%h, want 1 0 15 11111111222222223333333344444444",
                     ok, e, aw_n, d);
        else checks_passed++;
        checks_total++;
        if (w_log[12] !== 32'h1A02D73A || aw_log[12] !== 32'h20)
            $display("FAIL midrst_beat12: got addr=%h data=%h, want 00000020 1A02D73A", aw_log[12], w_log[12]);
        else checks_passed++;
    endtask

    initial begin
        checks_total = 0; checks_passed = 0;
        aw_delay = 0; w_delay = 0; err_idx = -1; clr_req = 0;
        rd_words = '{32'h0, 32'h0, 32'h0, 32'h0};
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_key = '0; cmd_ptext = '0; cmd_ctext = '0;
        test_reset();
        test_write_sequence();
        test_ready_skew();
        test_bresp_err();
        test_rsp_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
